// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller with multicycle E-stage scoreboard, memory-wait freeze
// and saturating stall/flush counters; all control outputs are combinational.
module hazard_ctrl_mc #(
   parameter int REG_AW   = 5,
   parameter int MC_LAT_W = 6,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic [REG_AW-1:0]   rs1_d_i,
   input  logic [REG_AW-1:0]   rs2_d_i,
   input  logic                rs1_use_d_i,
   input  logic                rs2_use_d_i,
   input  logic [REG_AW-1:0]   rs1_e_i,
   input  logic [REG_AW-1:0]   rs2_e_i,
   input  logic [REG_AW-1:0]   rd_e_i,
   input  logic                we_e_i,
   input  logic                load_e_i,
   input  logic                mc_start_e_i,
   input  logic [MC_LAT_W-1:0] mc_lat_e_i,
   input  logic [REG_AW-1:0]   rd_m_i,
   input  logic [REG_AW-1:0]   rd_w_i,
   input  logic                we_m_i,
   input  logic                we_w_i,
   input  logic                pcsrc_e_i,
   input  logic                mem_wait_i,
   output logic                stall_f_o,
   output logic                stall_d_o,
   output logic                stall_e_o,
   output logic                stall_m_o,
   output logic                flush_d_o,
   output logic                flush_e_o,
   output logic                bubble_m_o,
   output logic [1:0]          fwd_a_e_o,
   output logic [1:0]          fwd_b_e_o,
   output logic                mc_busy_o,
   output logic                mc_done_o,
   output logic [CNT_W-1:0]    stall_cnt_o,
   output logic [CNT_W-1:0]    flush_cnt_o
);

   typedef enum logic {IDLE, MC_RUN} state_t;

   state_t              state, state_nxt;
   logic [MC_LAT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0]    stall_cnt, flush_cnt;
   logic                mc_long, mc_hold, mc_done, lw_stall;

   // M-stage result is newer than W, so it wins on a double match.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic              we_m,
                                          input logic [REG_AW-1:0] rd_w,
                                          input logic              we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (rd_m != '0) && (rd_m == rs))
         sel = 2'b10;
      else if (we_w && (rd_w != '0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign mc_long  = mc_start_e_i && (mc_lat_e_i >= MC_LAT_W'(2));
   assign lw_stall = load_e_i && we_e_i && (rd_e_i != '0) &&
                     ((rs1_use_d_i && (rs1_d_i == rd_e_i)) ||
                      (rs2_use_d_i && (rs2_d_i == rd_e_i)));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mc_hold   = 1'b0;
      mc_done   = 1'b0;
      case (state)
         IDLE: begin
            mc_hold = mc_long;
            if (mc_long && !mem_wait_i) begin
               state_nxt = MC_RUN;
               cnt_nxt   = mc_lat_e_i - MC_LAT_W'(1);
            end
         end
         MC_RUN: begin
            // cnt counts remaining E cycles; a frozen cycle leaves it untouched.
            mc_hold = (cnt != MC_LAT_W'(1));
            if (!mem_wait_i) begin
               cnt_nxt = cnt - MC_LAT_W'(1);
               if (cnt == MC_LAT_W'(1)) begin
                  mc_done   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      stall_f_o  = 1'b0;
      stall_d_o  = 1'b0;
      stall_e_o  = 1'b0;
      stall_m_o  = 1'b0;
      flush_d_o  = 1'b0;
      flush_e_o  = 1'b0;
      bubble_m_o = 1'b0;
      fwd_a_e_o  = 2'b00;
      fwd_b_e_o  = 2'b00;
      mc_busy_o  = 1'b0;
      mc_done_o  = 1'b0;
      if (!rst_i) begin
         fwd_a_e_o = fwd_sel(rs1_e_i, rd_m_i, we_m_i, rd_w_i, we_w_i);
         fwd_b_e_o = fwd_sel(rs2_e_i, rd_m_i, we_m_i, rd_w_i, we_w_i);
         mc_busy_o = mc_hold;
         mc_done_o = mc_done;
         if (mem_wait_i) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            mc_done_o = 1'b0;
         end else if (mc_hold) begin
            stall_f_o  = 1'b1;
            stall_d_o  = 1'b1;
            stall_e_o  = 1'b1;
            bubble_m_o = 1'b1;
         end else if (pcsrc_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
         end else if (lw_stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (stall_f_o && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_e_o && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = rst_i ? '0 : stall_cnt;
   assign flush_cnt_o = rst_i ? '0 : flush_cnt;

endmodule
